// File: rtl/address_control_if.sv
// Bank-address bundle between the FFT sequencer and the address generator.
// The sequencer owns the master side; the address generator owns the slave side.
interface address_control_if #(
    parameter int AW = 3
);
    logic [AW-1:0] counter_r;
    logic [2:0]    stage_num_r;
    logic [AW-1:0] r_addr_0_1;
    logic [AW-1:0] r_addr_2_3;
    logic [AW-1:0] w_addr_0_1;
    logic [AW-1:0] w_addr_2_3;

    modport master (
        output counter_r,
        output stage_num_r,
        input  r_addr_0_1,
        input  r_addr_2_3,
        input  w_addr_0_1,
        input  w_addr_2_3
    );

    modport slave (
        input  counter_r,
        input  stage_num_r,
        output r_addr_0_1,
        output r_addr_2_3,
        output w_addr_0_1,
        output w_addr_2_3
    );
endinterface

// File: rtl/address_control.sv
// Bank-address generator for the radix-2 FFT memory (two butterflies per cycle).
// Optional ADDRCTL_BITREV_EN: bit-reverse write addresses in the last stage.
module address_control #(
    parameter int NUMSTAGES  = 5,
    parameter int PIPE_DEPTH = 3
) (
    input logic              clk,
    input logic              rst,
    address_control_if.slave bus
);
    localparam int AW = NUMSTAGES - 2;

    typedef struct packed {
        logic [AW-1:0] a01;
        logic [AW-1:0] a23;
        logic [2:0]    stg;
    } wr_t;

    // Bit i pairs with stage NUMSTAGES-1-i; stages 0/1 and idle never match.
    function automatic logic [AW-1:0] stage_mask(input logic [2:0] s);
        logic [AW-1:0] m;
        for (int i = 0; i < AW; i++) begin
            m[i] = (int'(s) == NUMSTAGES - 1 - i);
        end
        return m;
    endfunction

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = v[AW-1-i];
        end
        return r;
    endfunction

    logic [AW-1:0] r01;
    logic [AW-1:0] r23;
    logic [2:0]    stage_q;
    wr_t           line [PIPE_DEPTH];
    wr_t           tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            r01     <= '0;
            r23     <= '0;
            stage_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                line[i] <= '0;
            end
        end else begin
            r01     <= bus.counter_r;
            r23     <= bus.counter_r ^ stage_mask(bus.stage_num_r);
            stage_q <= bus.stage_num_r;
            line[0] <= {r01, r23, stage_q};
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign tail           = line[PIPE_DEPTH-1];
    assign bus.r_addr_0_1 = r01;
    assign bus.r_addr_2_3 = r23;

`ifdef ADDRCTL_BITREV_EN
    logic last_stage;
    assign last_stage     = (tail.stg == 3'(NUMSTAGES - 1));
    assign bus.w_addr_0_1 = last_stage ? bitrev(tail.a01) : tail.a01;
    assign bus.w_addr_2_3 = last_stage ? bitrev(tail.a23) : tail.a23;
`else
    assign bus.w_addr_0_1 = tail.a01;
    assign bus.w_addr_2_3 = tail.a23;
`endif

endmodule

// File: tb/tb_address_control.sv
// Randomised and directed checks of address_control against a history-based model.
// Model: read address = f(previous inputs); write address = read address P cycles back.
module tb_address_control;
    localparam int NS = 5;
    localparam int P  = 3;
    localparam int AW = NS - 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    bit   model_ok = 1'b0;

    address_control_if #(.AW(AW)) bus ();

    address_control #(.NUMSTAGES(NS), .PIPE_DEPTH(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Index 0 = newest registered read pair; index P = pair now on the write side.
    int h01 [P+1];
    int h23 [P+1];
    int hst [P+1];

    function automatic int mask_of(input int s);
        return (s >= 2 && s <= NS - 1) ? (1 << (NS - 1 - s)) : 0;
    endfunction

    function automatic int rev3(input int v);
        return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
    endfunction

    function automatic int exp_w(input int a, input int s);
`ifdef ADDRCTL_BITREV_EN
        return (s == NS - 1) ? rev3(a) : a;
`else
        return a;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= P; i++) begin
                h01[i] = 0;
                h23[i] = 0;
                hst[i] = 0;
            end
            model_ok = 1'b1;
        end else begin
            for (int i = P; i >= 1; i--) begin
                h01[i] = h01[i-1];
                h23[i] = h23[i-1];
                hst[i] = hst[i-1];
            end
            h01[0] = int'(bus.counter_r);
            h23[0] = int'(bus.counter_r) ^ mask_of(int'(bus.stage_num_r));
            hst[0] = int'(bus.stage_num_r);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_r01", int'(bus.r_addr_0_1), h01[0]);
            chk("model_r23", int'(bus.r_addr_2_3), h23[0]);
            chk("model_w01", int'(bus.w_addr_0_1), exp_w(h01[P], hst[P]));
            chk("model_w23", int'(bus.w_addr_2_3), exp_w(h23[P], hst[P]));
        end
    end

    task automatic set(input int c, input int s, input bit r);
        bus.counter_r   = AW'(c);
        bus.stage_num_r = 3'(s);
        rst             = r;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int sweep [5] = '{1, 1, 5, 3, 0};

    initial begin
        // Reset, then first transaction latency
        set(5, 0, 1);
        tickn(2);
        chk("rst_r01", int'(bus.r_addr_0_1), 0);
        chk("rst_r23", int'(bus.r_addr_2_3), 0);
        chk("rst_w01", int'(bus.w_addr_0_1), 0);
        chk("rst_w23", int'(bus.w_addr_2_3), 0);
        set(5, 0, 0);
        tick();
        chk("t1_r01", int'(bus.r_addr_0_1), 5);
        chk("t1_r23", int'(bus.r_addr_2_3), 5);
        chk("t1_w01_early", int'(bus.w_addr_0_1), 0);
        tickn(P);
        chk("t1_w01", int'(bus.w_addr_0_1), 5);
        chk("t1_w23", int'(bus.w_addr_2_3), 5);

        // Stage sweep with counter 1
        for (int s = 0; s < 5; s++) begin
            set(1, s, 0);
            tick();
            chk("sweep_r01", int'(bus.r_addr_0_1), 1);
            chk("sweep_r23", int'(bus.r_addr_2_3), sweep[s]);
        end

        // Full run then idle
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < 8; c++) begin
                set(c, s, 0);
                tick();
            end
        end
        set(3, 5, 0);
        tick();
        chk("idle_r01", int'(bus.r_addr_0_1), 3);
        chk("idle_r23", int'(bus.r_addr_2_3), 3);
        tickn(P + 1);

        // Last stage, write-side bit reversal
        set(6, 4, 0);
        tick();
        chk("s4_r01", int'(bus.r_addr_0_1), 6);
        chk("s4_r23", int'(bus.r_addr_2_3), 7);
        tickn(P);
`ifdef ADDRCTL_BITREV_EN
        chk("s4_w01", int'(bus.w_addr_0_1), 3);
`else
        chk("s4_w01", int'(bus.w_addr_0_1), 6);
`endif
        chk("s4_w23", int'(bus.w_addr_2_3), 7);

        // Reset mid-stage discards in-flight writes
        set(5, 3, 0);
        tickn(2);
        set(5, 3, 1);
        tick();
        chk("mid_r01", int'(bus.r_addr_0_1), 0);
        chk("mid_r23", int'(bus.r_addr_2_3), 0);
        chk("mid_w01", int'(bus.w_addr_0_1), 0);
        chk("mid_w23", int'(bus.w_addr_2_3), 0);
        set(0, 0, 0);
        for (int i = 0; i <= P; i++) begin
            tick();
            chk("stale_w01", int'(bus.w_addr_0_1), 0);
            chk("stale_w23", int'(bus.w_addr_2_3), 0);
        end

        // Counter wrap with stage step on the same edge
        set(7, 1, 0);
        tick();
        chk("wrap_r23_a", int'(bus.r_addr_2_3), 7);
        set(0, 2, 0);
        tick();
        chk("wrap_r23_b", int'(bus.r_addr_2_3), 4);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            set($urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom_range(0, 40) == 0));
            tick();
        end
        set(0, 0, 0);
        tickn(P + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
